// File: rtl/led_drv_pkg.sv
// Shared types for the LED channel driver: channel modes, config record and
// the per-channel output rule.
package led_drv_pkg;
  localparam int LED_CNT_W = 16;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_e;

  typedef struct packed {
    led_mode_e             mode;
    logic [LED_CNT_W-1:0]  period;
    logic [LED_CNT_W-1:0]  duty;
  } led_cfg_t;

  localparam led_cfg_t LED_CFG_RST = '{mode: LED_OFF, period: '0, duty: '0};

  function automatic logic led_level(input led_cfg_t c,
                                     input logic [LED_CNT_W-1:0] phase,
                                     input logic blink);
    logic lvl;
    lvl = 1'b0;
    case (c.mode)
      LED_OFF:   lvl = 1'b0;
      LED_ON:    lvl = 1'b1;
      LED_BLINK: lvl = blink;
      LED_PWM:   lvl = (phase < c.duty);
      default:   lvl = 1'b0;
    endcase
    return lvl;
  endfunction
endpackage

// File: rtl/led_chan.sv
// One LED channel: active/shadow config, phase counter, blink state and the
// registered output. Running BLINK/PWM configs are only replaced at a wrap.
module led_chan
  import led_drv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     tick,
  input  logic     wr_en,
  input  led_cfg_t wr_cfg,
  output logic     pending,
  output logic     led
);
  led_cfg_t             act, shd;
  logic [LED_CNT_W-1:0] phase;
  logic                 blink;
  logic                 direct, wrap;

  // Static modes have no period to protect, so they take writes at once.
  assign direct = (act.mode == LED_OFF) || (act.mode == LED_ON);
  assign wrap   = tick && (phase == act.period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act     <= LED_CFG_RST;
      shd     <= LED_CFG_RST;
      phase   <= '0;
      blink   <= 1'b0;
      pending <= 1'b0;
      led     <= 1'b0;
    end else begin
      led <= led_level(act, phase, blink);
      if (wr_en && direct) begin
        act   <= wr_cfg;
        phase <= '0;
        blink <= 1'b0;
      end else begin
        if (wrap && pending) begin
          act     <= shd;
          phase   <= '0;
          blink   <= 1'b0;
          pending <= 1'b0;
        end else if (wrap) begin
          phase <= '0;
          blink <= ~blink;
        end else if (tick) begin
          phase <= phase + LED_CNT_W'(1);
        end
        if (wr_en) begin
          shd     <= wr_cfg;
          pending <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/led_chan_driver.sv
// Multi-channel LED driver: one shared prescaler tick-enable feeding N_CH
// independent OFF/ON/BLINK/PWM channels behind a valid/ready config port.
module led_chan_driver
  import led_drv_pkg::*;
#(
  parameter int CLK_HZ  = 48_000_000,
  parameter int TICK_HZ = 10_000,
  parameter int N_CH    = 3,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [CNT_W-1:0]        cfg_duty,
  output logic [N_CH-1:0]         led,
  output logic                    tick
);
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = $clog2(DIV);
  localparam int CH_W = $clog2(N_CH);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("led_chan_driver: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (N_CH < 2 || CNT_W > LED_CNT_W) begin : g_bad_size
    $error("led_chan_driver: need N_CH >= 2 and CNT_W <= LED_CNT_W");
  end

  logic [PS_W-1:0]      ps_cnt;
  logic [N_CH-1:0]      pending;
  logic [2**CH_W-1:0]   pend_pad;
  logic                 accept;
  led_cfg_t             wr_cfg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + PS_W'(1);
  end
  assign tick = (ps_cnt == PS_W'(DIV - 1));

  // Unused channel codes read as "not pending", so they are accepted and dropped.
  always_comb begin
    pend_pad             = '0;
    pend_pad[N_CH-1:0]   = pending;
  end
  assign cfg_ready = ~pend_pad[cfg_ch];
  assign accept    = cfg_valid && cfg_ready;
  assign wr_cfg    = '{mode:   led_mode_e'(cfg_mode),
                       period: LED_CNT_W'(cfg_period),
                       duty:   LED_CNT_W'(cfg_duty)};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_chan u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .wr_en   (accept && (cfg_ch == CH_W'(i))),
      .wr_cfg  (wr_cfg),
      .pending (pending[i]),
      .led     (led[i])
    );
  end
endmodule

// File: tb/tb_led_chan_driver.sv
// Bench for led_chan_driver: table of steady-state patterns, hand-written
// handshake/reset sequences and random writes against a cycle reference model.
module tb_led_chan_driver;
  localparam int DIV = 2;

  logic        clk, rst;
  logic        cfg_valid, cfg_ready, tick;
  logic [1:0]  cfg_ch, cfg_mode;
  logic [15:0] cfg_period, cfg_duty;
  logic [2:0]  led;
  logic        d_ready, d_tick;
  logic [2:0]  d_led;

  int n_cmp = 0, n_fail = 0;
  bit chk_en = 0;

  led_chan_driver #(.CLK_HZ(8), .TICK_HZ(4), .N_CH(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .led(led), .tick(tick));

  led_chan_driver u_def (
    .clk(clk), .rst(rst), .cfg_valid(1'b0), .cfg_ready(d_ready),
    .cfg_ch(2'd0), .cfg_mode(2'd0), .cfg_period(16'd0),
    .cfg_duty(16'd0), .led(d_led), .tick(d_tick));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: channel state as plain integers, advanced once per clock.
  int m_cnt;
  int m_mode[3], m_per[3], m_duty[3], m_ph[3], m_blk[3], m_pend[3];
  int s_mode[3], s_per[3], s_duty[3];
  int m_led;

  function automatic int lvl(input int md, input int dt, input int ph, input int bk);
    case (md)
      1:       return 1;
      2:       return bk;
      3:       return (ph < dt) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_cnt = 0;
    m_led = 0;
    for (int c = 0; c < 3; c++) begin
      m_mode[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_ph[c] = 0;
      m_blk[c] = 0;  m_pend[c] = 0; s_mode[c] = 0; s_per[c] = 0; s_duty[c] = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        model_reset();
        chk("rst_led", int'(led), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_ready", int'(cfg_ready), 1);
      end else begin
        bit tk, rdy, acc;
        int nl;
        tk  = (m_cnt == DIV - 1);
        rdy = (cfg_ch >= 2'd3) ? 1'b1 : (m_pend[cfg_ch] == 0);
        chk("mdl_tick", int'(tick), int'(tk));
        chk("mdl_ready", int'(cfg_ready), int'(rdy));
        chk("mdl_led", int'(led), m_led);
        nl = 0;
        for (int c = 0; c < 3; c++) begin
          nl |= lvl(m_mode[c], m_duty[c], m_ph[c], m_blk[c]) << c;
          acc = cfg_valid && rdy && (int'(cfg_ch) == c);
          if (acc && m_mode[c] <= 1) begin
            m_mode[c] = cfg_mode; m_per[c] = cfg_period; m_duty[c] = cfg_duty;
            m_ph[c] = 0; m_blk[c] = 0;
          end else begin
            if (tk) begin
              if (m_ph[c] == m_per[c]) begin
                m_ph[c] = 0;
                if (m_pend[c] != 0) begin
                  m_mode[c] = s_mode[c]; m_per[c] = s_per[c]; m_duty[c] = s_duty[c];
                  m_blk[c] = 0; m_pend[c] = 0;
                end else m_blk[c] ^= 1;
              end else m_ph[c]++;
            end
            if (acc) begin
              s_mode[c] = cfg_mode; s_per[c] = cfg_period; s_duty[c] = cfg_duty;
              m_pend[c] = 1;
            end
          end
        end
        m_led = nl;
        m_cnt = tk ? 0 : m_cnt + 1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  // One-shot write attempt; acc reports whether it was accepted.
  task automatic wr(input int ch, input int md, input int per, input int dt, output bit acc);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(md);
    cfg_period = 16'(per);
    cfg_duty   = 16'(dt);
    @(negedge clk);
    acc = cfg_ready;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic sample(input int ch, output int hi, output int ed, output int oth);
    logic prev;
    hi = 0; ed = 0; oth = 0;
    @(negedge clk);
    prev = led[ch];
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      hi  += int'(led[ch]);
      ed  += (led[ch] != prev) ? 1 : 0;
      oth += ((led & ~(3'b001 << ch)) != 3'b000) ? 1 : 0;
      prev = led[ch];
    end
  endtask

  typedef struct { int ch; int md; int per; int dt; int hi; int ed; } vec_t;
  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int hi, ed, oth, seen, wait_n;
    int tt[2];
    string nm;

    tbl[0]  = '{0, 3, 3, 1, 12, 12};
    tbl[1]  = '{0, 3, 3, 3, 36, 12};
    tbl[2]  = '{0, 3, 3, 0,  0,  0};
    tbl[3]  = '{0, 3, 3, 5, 48,  0};
    tbl[4]  = '{1, 2, 2, 0, 24,  8};
    tbl[5]  = '{2, 2, 0, 0, 24, 24};
    tbl[6]  = '{2, 1, 0, 0, 48,  0};
    tbl[7]  = '{1, 0, 4, 2,  0,  0};
    tbl[8]  = '{1, 3, 1, 1, 24, 24};
    tbl[9]  = '{0, 3, 0, 1, 48,  0};
    tbl[10] = '{0, 2, 3, 0, 24,  6};
    tbl[11] = '{2, 3, 5, 2, 16,  8};

    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_duty = '0;
    chk_en = 1'b1;
    do_reset();

    chk("def_led_rst", int'(d_led), 0);
    chk("def_ready_rst", int'(d_ready), 1);
    chk("def_tick_rst", int'(d_tick), 0);
    chk("led_rst", int'(led), 0);
    chk("ready_rst", int'(cfg_ready), 1);

    // Default prescaler: tick spacing and width.
    seen = 0;
    for (int k = 0; k < 12000 && seen < 2; k++) begin
      @(negedge clk);
      if (d_tick) begin tt[seen] = k; seen++; end
    end
    chk("def_tick_seen", seen, 2);
    if (seen == 2) chk("def_tick_gap", tt[1] - tt[0], 4800);
    @(negedge clk);
    chk("def_tick_width", int'(d_tick), 0);
    chk("def_led_idle", int'(d_led), 0);
    cyc(1);

    // Steady-state patterns from a fresh reset.
    for (int v = 0; v < 12; v++) begin
      do_reset();
      wr(tbl[v].ch, tbl[v].md, tbl[v].per, tbl[v].dt, acc);
      nm = $sformatf("tbl%0d_acc", v);
      chk(nm, int'(acc), 1);
      cyc(4);
      sample(tbl[v].ch, hi, ed, oth);
      chk($sformatf("tbl%0d_high", v), hi, tbl[v].hi);
      chk($sformatf("tbl%0d_edges", v), ed, tbl[v].ed);
      chk($sformatf("tbl%0d_others", v), oth, 0);
      cyc(1);
    end

    // Mid-period duty change: held off until wrap, other channels unaffected.
    do_reset();
    wr(0, 3, 3, 1, acc);  chk("mid_first_acc", int'(acc), 1);
    cyc(3);
    wr(0, 3, 3, 3, acc);  chk("mid_update_acc", int'(acc), 1);
    wr(0, 3, 3, 7, acc);  chk("mid_second_held", int'(acc), 0);
    wr(1, 1, 0, 0, acc);  chk("mid_other_acc", int'(acc), 1);
    cfg_ch = 2'd0;
    wait_n = 0;
    while (wait_n < 40) begin
      @(negedge clk);
      if (cfg_ready) break;
      wait_n++;
    end
    chk("mid_ready_back", int'(cfg_ready), 1);
    cyc(3);
    sample(0, hi, ed, oth);
    chk("mid_new_high", hi, 36);
    chk("mid_new_edges", ed, 12);
    chk("mid_led1_on", int'(led[1]), 1);
    cyc(1);

    // ON latency and out-of-range channel.
    do_reset();
    wr(2, 1, 0, 0, acc);
    chk("on_acc", int'(acc), 1);
    chk("on_lag1", int'(led[2]), 0);
    cyc(1);
    chk("on_lag2", int'(led[2]), 1);
    wr(3, 3, 5, 5, acc);
    chk("ch3_acc", int'(acc), 1);
    cyc(6);
    chk("ch3_nochange", int'(led), 3'b100);

    // Async reset during a pending BLINK update.
    do_reset();
    wr(1, 2, 3, 0, acc);  chk("ar_blink_acc", int'(acc), 1);
    cyc(3);
    wr(1, 2, 1, 0, acc);  chk("ar_pend_acc", int'(acc), 1);
    cfg_ch = 2'd1;
    @(negedge clk);
    chk("ar_pend_ready", int'(cfg_ready), 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_led_now", int'(led), 0);
    chk("ar_ready_now", int'(cfg_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(20);
    chk("ar_chan_off", int'(led), 0);
    chk("ar_ready_after", int'(cfg_ready), 1);

    // Random writes checked every cycle by the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_period = 16'($urandom_range(0, 5));
      cfg_duty   = 16'($urandom_range(0, 7));
      cfg_valid  = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    cfg_valid = 1'b0;
    cyc(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/led_chan_driver.md
Name: led_chan_driver

Overview:
- Next-generation multi-channel LED driver. Replaces per-channel cascaded clock dividers with one shared prescaler tick-enable; all logic runs on the single system clock.
- N_CH independent channels, each runtime-configurable for OFF/ON/BLINK/PWM mode with programmable period and duty.
- Configured through a valid/ready write port; drives the board RGB LED pins (N_CH=3) or wider LED banks.

Parameters:
- CLK_HZ, 48_000_000, system clock frequency.
- TICK_HZ, 10_000, prescaler tick rate. DIV = CLK_HZ/TICK_HZ must be an integer and at least 2 (elaboration-time assertion).
- N_CH, 3, channel count, minimum 2.
- CNT_W, 16, phase/period/duty width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accept
- cfg_ch  in  $clog2(N_CH)  target channel
- cfg_mode  in  2  0=OFF 1=ON 2=BLINK 3=PWM
- cfg_period  in  CNT_W  phase wraps after period+1 ticks
- cfg_duty  in  CNT_W  PWM high ticks per period
- led  out  N_CH  registered LED outputs
- tick  out  1  prescaler strobe, one clk wide

Behaviour:
- Reset (async assert, sync release): led=0, tick=0, prescaler=0. Every channel: mode=OFF, period=0, duty=0, phase=0, blink=0, pending=0. cfg_ready=1.
- Prescaler: counts 0..DIV-1 and wraps. tick=1 for exactly the cycle in which count==DIV-1.
- Phase, per channel, on tick only: if phase==period then phase<=0 (wrap event), else phase<=phase+1. Unsigned CNT_W arithmetic; the phase counter never passes period.
- BLINK: blink toggles on each wrap event, so led toggles every period+1 ticks.
- led output, per channel, registered every cycle:
  - OFF: 0
  - ON: 1
  - BLINK: blink
  - PWM: (phase < duty)
  - led therefore lags the active state by one cycle.
- Handshake:
  - cfg_ready = !pending[cfg_ch] when cfg_ch < N_CH; cfg_ready = 1 otherwise.
  - Accept = cfg_valid && cfg_ready. An accept with cfg_ch >= N_CH is dropped silently.
- Accept when the active mode is OFF or ON:
  - Write goes straight to active registers next edge; phase=0, blink=0, no pending.
  - led reflects the new config 2 cycles after the accept cycle.
- Accept when the active mode is BLINK or PWM:
  - Write goes to shadow registers; pending=1.
  - Commit happens on the next wrap event of that channel: active<=shadow, phase<=0, blink<=0, pending<=0.
  - Output is glitch-free; the running period always completes.
- While pending=1, cfg_ready stays low for that channel only. Other channels still accept writes.
- Duty/period edge cases:
  - duty=0: PWM output constant 0.
  - duty>period: constant 1.
  - period=0: BLINK toggles every tick; PWM with duty>=1 gives constant 1.
- Priority: reset wins over everything. A commit and a wrap in the same cycle follow the commit rule (phase=0).
- Async reset mid-operation clears shadow and pending state; no partial config survives.

Decomposition:
- Package led_drv_pkg:
  - enum led_mode_e {LED_OFF, LED_ON, LED_BLINK, LED_PWM}
  - struct led_cfg_t {mode, period, duty}, parameterised via CNT_W localparam default
- Sub-module led_chan: one channel holding active/shadow cfg, phase, blink, pending and the led register. Generated N_CH times.
- Prescaler and cfg_ready muxing stay in the top module.

Test Plan:
- Defaults, reset release -> led=000, cfg_ready=1, tick every 4800 clk, exactly 1 clk wide.
- CLK_HZ=8, TICK_HZ=4 (DIV=2); ch0 PWM period=3 duty=1 -> led[0] high 2 clk, low 6 clk, repeating; led[1], led[2] stay 0.
- Same params; ch1 BLINK period=2 -> led[1] toggles every 6 clk. ch2 ON -> led[2]=1 exactly 2 cycles after the accept.
- ch0 PWM running, write duty=3 mid-period -> cfg_ready low until wrap; a second ch0 write is held off; a ch1 write during that window is accepted; from phase 0 onward led[0] is high 6 clk of 8.
- Boundaries: duty=0 -> always 0; period=3 duty=5 -> always 1; BLINK period=0 -> toggles every tick; cfg_ch=3 with N_CH=3 -> accepted, no state change.
- Assert rst asynchronously between edges during a pending BLINK update -> led=000 immediately, pending cleared, cfg_ready=1, channel returns to OFF.
